// File: rtl/freq_meter.sv
// freq_meter: gated edge-counting frequency meter with an Avalon-MM slave.
// sig_in rising edges are counted over a programmable gate window of clk
// cycles; COUNT holds the result of the last completed window.
// Optional build macro: FREQ_METER_PERIOD_EN adds a period counter that
// measures clk cycles between the last two sig_in rising edges (PERIOD, OVF).
// Without the macro, PERIOD and OVF read as 0.
//
// Register map (word addresses):
//   0 GATE   RW  gate window length in clk cycles (a written 0 is stored as 1)
//   1 COUNT  RO  rising edges in the last completed window; reading clears VALID
//   2 STATUS RO  bit0 VALID, bit1 OVF
//   3 PERIOD RO  clk cycles between the last two rising edges; reading clears OVF
module freq_meter #(
  parameter logic [31:0] GATE_DEFAULT = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        sig_in
);

  localparam logic [1:0]  ADDR_GATE   = 2'd0;
  localparam logic [1:0]  ADDR_COUNT  = 2'd1;
  localparam logic [1:0]  ADDR_STATUS = 2'd2;
  localparam logic [1:0]  ADDR_PERIOD = 2'd3;
  localparam logic [31:0] CNT_MAX     = 32'hFFFF_FFFF;

  // ---------------------------------------------------------------------------
  // Synchronizer and edge detector
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q, sync3_q;
  logic sync1_d, sync2_d, sync3_d;
  logic edge_pulse;

  // Two-flop synchronizer followed by a third flop used only for edge detection
  always_comb begin
    sync1_d    = sig_in;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;
    edge_pulse = sync2_q & ~sync3_q;
  end

  // Synchronizer state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic gate_wr;
  logic rd_en;
  logic rd_count;
  logic rd_period;

  // Only GATE is writable; reads are single-cycle with no wait states
  always_comb begin
    gate_wr   = chipselect & write & (address == ADDR_GATE);
    rd_en     = chipselect & read;
    rd_count  = rd_en & (address == ADDR_COUNT);
    rd_period = rd_en & (address == ADDR_PERIOD);
  end

  // ---------------------------------------------------------------------------
  // Gate window and edge counting
  // ---------------------------------------------------------------------------
  logic [31:0] gate_q, gate_d;
  logic [31:0] gate_cnt_q, gate_cnt_d;
  logic [31:0] edge_cnt_q, edge_cnt_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        window_done;
  logic [31:0] edge_inc;

  // Window sequencing: a GATE write restarts the window and takes priority
  // over a completion in the same cycle, so COUNT and VALID stay untouched.
  // edge_cnt needs no saturation: one edge per two clk cycles at most keeps
  // it below GATE/2+1.
  always_comb begin
    edge_inc    = {31'd0, edge_pulse};
    window_done = (gate_cnt_q == (gate_q - 32'd1));
    gate_d      = gate_q;
    gate_cnt_d  = gate_cnt_q + 32'd1;
    edge_cnt_d  = edge_cnt_q + edge_inc;
    count_d     = count_q;
    if (gate_wr) begin
      gate_d     = (writedata == 32'd0) ? 32'd1 : writedata;
      gate_cnt_d = 32'd0;
      edge_cnt_d = 32'd0;
    end else if (window_done) begin
      count_d    = edge_cnt_q + edge_inc;
      gate_cnt_d = 32'd0;
      edge_cnt_d = 32'd0;
    end
  end

  // VALID: cleared by a COUNT read, but a completing window wins
  always_comb begin
    valid_d = valid_q;
    if (rd_count) begin
      valid_d = 1'b0;
    end
    if (window_done && !gate_wr) begin
      valid_d = 1'b1;
    end
  end

  // Window state; reset discards any partial window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_q     <= GATE_DEFAULT;
      gate_cnt_q <= 32'd0;
      edge_cnt_q <= 32'd0;
      count_q    <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      gate_q     <= gate_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional period measurement
  // ---------------------------------------------------------------------------
  logic [31:0] period_val;
  logic        ovf_val;

`ifdef FREQ_METER_PERIOD_EN
  logic [31:0] period_cnt_q, period_cnt_d;
  logic [31:0] period_q, period_d;
  logic        ovf_q, ovf_d;
  logic        seen_q, seen_d;

  // period_cnt free-runs and saturates; each edge captures the interval.
  // The first edge after reset only marks the start of an interval.
  // OVF is raised when the counter reaches saturation; a PERIOD read clears
  // it, but a saturation in the same cycle wins.
  always_comb begin
    period_cnt_d = (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + 32'd1;
    period_d     = period_q;
    ovf_d        = ovf_q;
    seen_d       = seen_q;
    if (rd_period) begin
      ovf_d = 1'b0;
    end
    if (edge_pulse) begin
      if (seen_q) begin
        period_d = (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + 32'd1;
      end
      period_cnt_d = 32'd0;
      seen_d       = 1'b1;
    end else if (period_cnt_q == (CNT_MAX - 32'd1)) begin
      ovf_d = 1'b1;
    end
  end

  // Period state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt_q <= 32'd0;
      period_q     <= 32'd0;
      ovf_q        <= 1'b0;
      seen_q       <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;
      period_q     <= period_d;
      ovf_q        <= ovf_d;
      seen_q       <= seen_d;
    end
  end

  // Expose period registers to the read mux
  always_comb begin
    period_val = period_q;
    ovf_val    = ovf_q;
  end
`else
  // Period logic absent: PERIOD and OVF read as zero
  always_comb begin
    period_val = 32'd0;
    ovf_val    = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Registered read data
  // ---------------------------------------------------------------------------
  logic [31:0] readdata_q, readdata_d;

  // Read mux samples current register values, so a read coinciding with a
  // window completion returns the previous COUNT
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      case (address)
        ADDR_GATE:   readdata_d = gate_q;
        ADDR_COUNT:  readdata_d = count_q;
        ADDR_STATUS: readdata_d = {30'd0, ovf_val, valid_q};
        ADDR_PERIOD: readdata_d = period_val;
        default:     readdata_d = 32'd0;
      endcase
    end
  end

  // Read data register, held between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= 32'd0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule
